filter_window_ctrl: RTL

Sequencer for the 3x3 filter window datapath (shift register plus two line buffers). It accepts a raster pixel stream over a valid/ready handshake and tracks column and row position within a runtime-configured frame. It drives the datapath shift enable and the line-buffer address and write strobe. It flags when the window holds a complete 3x3 neighbourhood and holds that window under downstream backpressure.

---
 rtl/filter_pkg.sv | 17 +
 rtl/filter_window_ctrl_raster_counter.sv | 36 +++
 rtl/filter_window_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the 3x3 filter window sequencer.
package filter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    // Smallest frame dimension that still yields a full 3x3 neighbourhood
    localparam int unsigned MIN_DIM = 3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_ACTIVE = ST_ACTIVE,
        S_DRAIN  = ST_DRAIN
    } state_t;

endpackage

// File: rtl/filter_window_ctrl_raster_counter.sv
// Raster column/row position tracker with end-of-line and end-of-frame flags.
module raster_counter #(
    parameter int unsigned CW = 10,
    parameter int unsigned RW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    input  logic [CW-1:0] width,
    input  logic [RW-1:0] height,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          last_col,
    output logic          last_pix
);

    assign last_col = (col == width - CW'(1));
    assign last_pix = last_col && (row == height - RW'(1));

    // Advance one pixel per accept; wrap column at line end and row at frame end
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (adv) begin
            if (last_col) begin
                col <= '0;
                row <= last_pix ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/filter_window_ctrl.sv
// Sequencer for the 3x3 filter window datapath: pixel handshake, line-buffer
// addressing and window-valid presentation with downstream backpressure.
module filter_window_ctrl
    import filter_pkg::*;
#(
    parameter int unsigned CW = 10,
    parameter int unsigned RW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] cfg_width,
    input  logic [RW-1:0] cfg_height,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          shift_en,
    output logic [CW-1:0] lb_addr,
    output logic          lb_wr_en,
    output logic          win_valid,
    input  logic          out_ready,
    output logic [CW-1:0] win_col,
    output logic [RW-1:0] win_row
);

    state_t        state;
    state_t        state_next;
    logic          done_next;
    logic          err_next;
    logic          load_cfg;
    logic          cfg_ok;
    logic          frame_end;
    logic          qualify;
    logic [CW-1:0] width_q;
    logic [RW-1:0] height_q;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_col;
    logic          last_pix;

    raster_counter #(
        .CW (CW),
        .RW (RW)
    ) u_raster (
        .clk      (clk),
        .rst      (rst),
        .clr      (load_cfg),
        .adv      (shift_en),
        .width    (width_q),
        .height   (height_q),
        .col      (col),
        .row      (row),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    assign cfg_ok    = (cfg_width >= CW'(MIN_DIM)) && (cfg_height >= RW'(MIN_DIM));
    // A held window blocks new pixels unless it is being consumed this cycle
    assign in_ready  = (state == S_ACTIVE) && (!win_valid || out_ready);
    assign shift_en  = in_valid && in_ready;
    assign lb_wr_en  = shift_en;
    assign lb_addr   = col;
    assign busy      = (state != S_IDLE);
    assign frame_end = shift_en && last_col && last_pix;
    // Border fill: only accepts past the first two columns and rows complete a window
    assign qualify   = shift_en && (col >= CW'(2)) && (row >= RW'(2));

    // State register and registered status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_next;
            done    <= done_next;
            cfg_err <= err_next;
        end
    end

    // Next-state and pulse decode
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        err_next   = 1'b0;
        load_cfg   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        load_cfg   = 1'b1;
                        state_next = S_ACTIVE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (frame_end) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!win_valid) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Frame geometry captured on an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            width_q  <= '0;
            height_q <= '0;
        end else if (load_cfg) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
        end
    end

    // Window register: load on a qualifying accept, otherwise drop once consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_col   <= '0;
            win_row   <= '0;
        end else if (qualify) begin
            win_valid <= 1'b1;
            win_col   <= col - CW'(1);
            win_row   <= row - RW'(1);
        end else if (out_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule
